// File: rtl/cache_arbiter.sv
// cache_arbiter
// Arbitrates I-cache and D-cache line traffic onto one physical-memory port.
// Only one transaction is in flight at a time. On simultaneous requests the
// side that did not win last time is granted (round-robin).
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_read, i_addr              I-cache line-fill request (held until i_resp)
//   i_rdata, i_resp             I-cache returned line and one-cycle completion
//   d_read, d_write, d_addr     D-cache fill / write-back request (held until d_resp)
//   d_wdata                     D-cache write-back line
//   d_rdata, d_resp             D-cache returned line and one-cycle completion
//   pmem_read, pmem_write       memory strobes, held until pmem_resp
//   pmem_addr, pmem_wdata       memory line address (32-byte aligned) and write data
//   pmem_rdata, pmem_resp       memory read data and completion
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state_r;
  logic   last_grant_r;   // 0 = I served last, 1 = D served last
  logic   i_pending_s;
  logic   d_pending_s;
  logic   grant_i_s;
  logic   grant_d_s;

  // Byte-offset bits of the request addresses never reach memory.
  logic   addr_low_unused_s;
  assign addr_low_unused_s = ^{i_addr[4:0], d_addr[4:0]};

  // Grant decision for the IDLE state: round-robin on a tie.
  always_comb begin
    i_pending_s = i_read;
    d_pending_s = d_read | d_write;
    grant_i_s   = 1'b0;
    grant_d_s   = 1'b0;
    if (i_pending_s && d_pending_s) begin
      grant_i_s = last_grant_r;
      grant_d_s = ~last_grant_r;
    end else begin
      grant_i_s = i_pending_s;
      grant_d_s = d_pending_s;
    end
  end

  // Arbiter FSM; the pmem_* registers double as the latched address, data
  // and operation of the granted request, so memory never sees live inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_addr    <= {ADDR_W{1'b0}};
      pmem_wdata   <= {LINE_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_i_s) begin
            state_r      <= SERVE_I;
            last_grant_r <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            pmem_addr    <= {i_addr[ADDR_W-1:5], 5'b00000};
            pmem_wdata   <= {LINE_W{1'b0}};
          end else if (grant_d_s) begin
            // Read and write both high is treated as a write-back.
            state_r      <= SERVE_D;
            last_grant_r <= 1'b1;
            pmem_read    <= ~d_write;
            pmem_write   <= d_write;
            pmem_addr    <= {d_addr[ADDR_W-1:5], 5'b00000};
            pmem_wdata   <= d_write ? d_wdata : {LINE_W{1'b0}};
          end else begin
            state_r      <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_addr    <= {ADDR_W{1'b0}};
            pmem_wdata   <= {LINE_W{1'b0}};
          end
        end
        SERVE_I, SERVE_D: begin
          // Grant is held until memory completes, even if the requester drops.
          if (pmem_resp) begin
            state_r    <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            pmem_addr  <= {ADDR_W{1'b0}};
            pmem_wdata <= {LINE_W{1'b0}};
          end else begin
            state_r    <= state_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
          pmem_addr  <= {ADDR_W{1'b0}};
          pmem_wdata <= {LINE_W{1'b0}};
        end
      endcase
    end
  end

  // Completion pulses and read data pass straight through in the resp cycle;
  // pmem_resp in IDLE produces nothing.
  always_comb begin
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    i_rdata = {LINE_W{1'b0}};
    d_rdata = {LINE_W{1'b0}};
    if (pmem_resp && (state_r == SERVE_I)) begin
      i_resp  = 1'b1;
      i_rdata = pmem_rdata;
    end else if (pmem_resp && (state_r == SERVE_D)) begin
      d_resp  = 1'b1;
      d_rdata = pmem_rdata;
    end else begin
      i_resp  = 1'b0;
      d_resp  = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  localparam logic [LINE_W-1:0] DATA_A  = {8{32'hAAAA_0001}};
  localparam logic [LINE_W-1:0] DATA_B  = {8{32'hBBBB_0002}};
  localparam logic [LINE_W-1:0] DATA_C  = {8{32'hCCCC_0003}};
  localparam logic [LINE_W-1:0] DATA_D  = {8{32'hDDDD_0004}};
  localparam logic [LINE_W-1:0] DATA_E  = {8{32'hEEEE_0005}};
  localparam logic [LINE_W-1:0] DATA_W  = {8{32'h1234_5678}};
  localparam logic [LINE_W-1:0] DATA_W2 = {8{32'h0F0F_F0F0}};

  logic              clk;
  logic              rst_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {side (1 = D), expected rdata}
  logic [LINE_W:0] exp_q[$];
  logic [LINE_W:0] mon_e;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each response pulse.
  always @(negedge clk) begin
    if (pmem_read || pmem_write)
      chk1("strobe_excl", pmem_read & pmem_write, 1'b0);
    if (i_resp || d_resp) begin
      if (i_resp && d_resp) begin
        chk1("resp_excl", 1'b1, 1'b0);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b expected none at %0t", i_resp, d_resp, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk1("resp_side", d_resp, mon_e[LINE_W]);
        chkw("resp_rdata", d_resp ? d_rdata : i_rdata, mon_e[LINE_W-1:0]);
      end
    end
    if (pmem_resp && !i_resp) chkw("i_rdata_zero", i_rdata, {LINE_W{1'b0}});
    if (pmem_resp && !d_resp) chkw("d_rdata_zero", d_rdata, {LINE_W{1'b0}});
  end

  // Memory model for one transaction: waits for the strobe, checks it,
  // responds after 'delay' cycles, then drops the granted requester.
  task automatic serve(input logic side_d, input logic wr, input logic [ADDR_W-1:0] exp_addr,
                       input logic [LINE_W-1:0] exp_wdata, input logic [LINE_W-1:0] rdata,
                       input int delay, input logic immediate);
    int n;
    n = 0;
    @(negedge clk);
    while (!(pmem_read || pmem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(pmem_read || pmem_write)) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no strobe expected strobe at %0t", $time);
      return;
    end
    if (immediate) chkw("grant_latency", LINE_W'(n), {LINE_W{1'b0}});
    chk1("pmem_read", pmem_read, ~wr);
    chk1("pmem_write", pmem_write, wr);
    chkw("pmem_addr", LINE_W'(pmem_addr), LINE_W'(exp_addr));
    if (wr) chkw("pmem_wdata", pmem_wdata, exp_wdata);
    repeat (delay) @(posedge clk);
    #1;
    chk1("strobe_held", pmem_read | pmem_write, 1'b1);
    exp_q.push_back({side_d, rdata});
    pmem_resp  = 1'b1;
    pmem_rdata = rdata;
    @(posedge clk);
    #1;
    pmem_resp  = 1'b0;
    pmem_rdata = {LINE_W{1'b0}};
    if (side_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    @(negedge clk);
    chk1("idle_gap", pmem_read | pmem_write, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    rst_n = 1'b0; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    #12;
    chk1("rst_pmem_read", pmem_read, 1'b0);
    chk1("rst_pmem_write", pmem_write, 1'b0);
    chkw("rst_pmem_addr", LINE_W'(pmem_addr), {LINE_W{1'b0}});
    chkw("rst_pmem_wdata", pmem_wdata, {LINE_W{1'b0}});
    chk1("rst_i_resp", i_resp, 1'b0);
    chk1("rst_d_resp", d_resp, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // I-cache fill, no combinational path from request to strobe
    @(posedge clk); #1;
    i_read = 1'b1; i_addr = 32'h0000_1234;
    @(negedge clk);
    chk1("no_comb_path", pmem_read, 1'b0);
    serve(1'b0, 1'b0, 32'h0000_1220, '0, DATA_A, 3, 1'b1);

    // D-cache write-back
    d_write = 1'b1; d_addr = 32'h8000_0040; d_wdata = DATA_W;
    serve(1'b1, 1'b1, 32'h8000_0040, DATA_W, DATA_B, 2, 1'b1);

    // D read whose requester drops one cycle after grant
    d_read = 1'b1; d_addr = 32'h0000_0ABC;
    @(posedge clk);
    @(posedge clk); #1;
    d_read = 1'b0;
    serve(1'b1, 1'b0, 32'h0000_0AA0, '0, DATA_C, 2, 1'b0);

    // Stray pmem_resp in IDLE
    @(posedge clk); #1;
    pmem_resp = 1'b1; pmem_rdata = DATA_D;
    @(negedge clk);
    chk1("stray_i_resp", i_resp, 1'b0);
    chk1("stray_d_resp", d_resp, 1'b0);
    @(posedge clk); #1;
    pmem_resp = 1'b0; pmem_rdata = '0;
    @(negedge clk);
    chk1("stray_stays_idle", pmem_read | pmem_write, 1'b0);

    // Read and write together -> write
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_2000; d_wdata = DATA_W2;
    serve(1'b1, 1'b1, 32'h0000_2000, DATA_W2, DATA_E, 1, 1'b1);

    // Reset during SERVE_I abandons the transaction
    i_read = 1'b1; i_addr = 32'h0000_3000;
    @(negedge clk);
    chk1("serve_i_before_rst", pmem_read, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("rst_abort_read", pmem_read, 1'b0);
    @(posedge clk); #1;
    pmem_resp = 1'b1; pmem_rdata = DATA_A;
    @(posedge clk); #1;
    pmem_resp = 1'b0; pmem_rdata = '0; i_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("idle_after_rst", pmem_read | pmem_write, 1'b0);

    // Ties after reset: I first, then D, then I again
    i_read = 1'b1; i_addr = 32'h0000_4000; d_read = 1'b1; d_addr = 32'h0000_5000;
    serve(1'b0, 1'b0, 32'h0000_4000, '0, DATA_A, 1, 1'b1);
    serve(1'b1, 1'b0, 32'h0000_5000, '0, DATA_B, 1, 1'b1);
    i_read = 1'b1; i_addr = 32'h0000_6000; d_read = 1'b1; d_addr = 32'h0000_7000;
    serve(1'b0, 1'b0, 32'h0000_6000, '0, DATA_C, 1, 1'b1);
    serve(1'b1, 1'b0, 32'h0000_7000, '0, DATA_D, 1, 1'b1);

    repeat (3) @(negedge clk);
    chkw("scoreboard_empty", LINE_W'(exp_q.size()), {LINE_W{1'b0}});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
